score_rx_deframer: RTL and testbench
====================================

# score_rx_deframer

Receive-side deframer for the two-player score link. It consumes bytes from the UART receiver (`dout`/`rdy`/`rdy_clr`) in the `pclk` domain. It hunts for a sync byte, then reassembles the opponent's 24-bit packed-BCD score, MSB byte first. It validates the frame and presents the score, with a one-cycle update strobe, to the on-screen score renderer. It is the counterpart of the transmit path that serialises our own `BCD_out` onto `tx1`/`tx2`.

## Interface
- `SYNC_BYTE`, 8'hA5: frame start marker. It can never be a valid BCD byte.
- `BYTE_TIMEOUT`, 750000: maximum idle cycles between bytes inside a frame (10 ms at 75 MHz).
- `LINK_TIMEOUT`, 75000000: cycles without a good frame before `link_up` drops (1 s).
- `pclk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rx_byte` in 8: received byte (UART `dout`).
- `rx_rdy` in 1: UART byte-ready level. It stays high until cleared.
- `rx_rdy_clr` out 1: one-cycle clear pulse to the UART.
- `opp_score` out 24: last good score, packed BCD. It is held between frames.
- `score_valid` out 1: one-cycle pulse when `opp_score` updates.
- `frame_err` out 1: one-cycle pulse on any frame rejection.
- `err_cnt` out 8: saturating count of rejected frames.
- `link_up` out 1: high while good frames arrive within `LINK_TIMEOUT`.

## Operation
- **Reset values:** state HUNT, all outputs 0, both timers 0.
- **Byte acceptance:** a byte is accepted at an edge when `rx_rdy`=1 and the guard is idle.
  - `rx_rdy_clr`=1 for exactly the next cycle.
  - The guard then blocks acceptance for 2 edges, so a still-high `rdy` is never consumed twice.
- **States:** HUNT → B2 → B1 → B0 → (CHK) → HUNT.
  - HUNT: discard every byte except `SYNC_BYTE`, which moves to B2.
  - B2, B1, B0: capture `opp_score[23:16]`, `[15:8]`, `[7:0]` respectively into a shadow register, never directly into the outputs.
  - Each byte is checked: both nibbles must be ≤ 9.
  - A byte with a nibble > 9 gives `frame_err` and a move to HUNT.
  - Exception: if that byte equals `SYNC_BYTE`, the frame restarts at B2 and `frame_err` still pulses.
- **Commit:** after the last byte (B0, or CHK when enabled), the shadow value goes to `opp_score`.
  - `score_valid` pulses on the same edge.
  - The `LINK_TIMEOUT` timer reloads and `link_up`=1.
  - The frame commits even when the value equals the current `opp_score`.
- **Byte timeout:** the `BYTE_TIMEOUT` counter runs in every state except HUNT and resets on each accepted byte. On reaching the limit: `frame_err` pulses, the shadow is discarded and the state returns to HUNT.
- **Error counter:** `err_cnt` increments on each `frame_err` and saturates at 255.
- **Link timeout:** when the `LINK_TIMEOUT` counter expires, `link_up`=0 and `opp_score` is retained.
- **Reset mid-frame:** immediate return to HUNT. Partial data is lost.

## Timing
- `rx_rdy_clr` rises 1 cycle after the accepting edge.
- `score_valid` and the `opp_score` update occur on the edge that accepts the final byte. All outputs are registered.
- Minimum byte spacing is 3 cycles; the UART byte rate is far slower.
- A timeout and a byte acceptance on the same edge: the acceptance wins and the timer resets.
- A link expiry and a commit on the same edge: the commit wins and `link_up` stays 1.

## Configuration
- **`SCORE_RX_CHECKSUM_EN` defined:** a fourth payload byte is expected, equal to B2^B1^B0.
  - In state CHK the byte is never interpreted as sync, even if it equals 8'hA5.
  - A mismatch gives `frame_err`, a move to HUNT, and no commit.
- **Not defined:** the frame is 4 bytes (sync + 3), and the commit happens on B0.
- The transmit side must be built with the same setting.

## Structure
- **Shared package `score_link_pkg`:**
  - `SYNC_BYTE` default.
  - State enum (HUNT, B2, B1, B0, CHK).
  - Frame-length constants for both configurations.
  - Checksum function.
  - This package is also used by the transmit framer.
- **Sub-module `score_rx_timer`:** loadable down-counter with an expiry flag. It is instantiated twice: for the byte timeout and for the link timeout.

## Test plan
- **Good frame, checksum off:** A5,12,34,56 → `opp_score`=24'h123456 and `score_valid` pulses once. `link_up`=1, with one `rx_rdy_clr` pulse per byte.
- **Good frame, checksum on:** A5,98,76,54,BA → `opp_score`=24'h987654. The same frame with checksum 00 → `frame_err`, `err_cnt`=1, `opp_score` unchanged.
- **Resync:** A5,12,A5,00,01,99 → one `frame_err`, then `opp_score`=24'h000199.
- **Bad BCD and noise in HUNT:** 3C,A5,1F → `frame_err` on 1F only, and the next good frame commits.
- **Timeouts:**
  - Stop after A5,12 for `BYTE_TIMEOUT` cycles → `frame_err` and HUNT.
  - No frames for `LINK_TIMEOUT` → `link_up`=0 with `opp_score` held.
  - Hold `rx_rdy` high for 5 cycles → exactly one byte accepted.
- **Reset mid-frame:** assert `rst` low after A5,12 → all outputs 0 immediately. A following full frame decodes correctly, and `err_cnt` saturates at 255 after 300 bad frames.

Source files
------------

// File: rtl/score_link_pkg.sv
// -----------------------------------------------------------------------------
// score_link_pkg
// Shared definitions for the two-player score link, used by both the receive
// deframer and the transmit framer so that the two ends always agree on the
// frame format.
//
// Contents:
//   SYNC_BYTE        frame start marker (never a valid packed-BCD byte)
//   FRAME_LEN_PLAIN  bytes per frame without checksum (sync + 3 payload)
//   FRAME_LEN_CHK    bytes per frame with checksum (sync + 3 payload + check)
//   rx_state_e       deframer state encoding (HUNT, B2, B1, B0, CHK)
//   frame_checksum() XOR of the three payload bytes
//   bcd_byte_ok()    true when both nibbles of a byte are decimal digits
//
// The checksum byte is only present when SCORE_RX_CHECKSUM_EN is defined on
// both the transmit and the receive side.
// -----------------------------------------------------------------------------
package score_link_pkg;

   localparam logic [7:0]  SYNC_BYTE       = 8'hA5;
   localparam int unsigned FRAME_LEN_PLAIN = 32'd4;
   localparam int unsigned FRAME_LEN_CHK   = 32'd5;

   typedef enum logic [2:0] {
      HUNT = 3'd0,
      B2   = 3'd1,
      B1   = 3'd2,
      B0   = 3'd3,
      CHK  = 3'd4
   } rx_state_e;

   // XOR of the three payload bytes, MSB byte first in the packed score.
   function automatic logic [7:0] frame_checksum(input logic [23:0] payload);
      return payload[23:16] ^ payload[15:8] ^ payload[7:0];
   endfunction

   // Both nibbles must be 0..9 for the byte to be packed BCD.
   function automatic logic bcd_byte_ok(input logic [7:0] b);
      return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
   endfunction

endpackage

// File: rtl/score_rx_timer.sv
// -----------------------------------------------------------------------------
// score_rx_timer
// Loadable down-counter with an expiry flag. Used by the deframer for both the
// inter-byte timeout and the link-alive timeout.
//
// Ports:
//   pclk      clock, rising edge
//   rst       asynchronous active-low reset (count and flag reflect zero)
//   load      load load_val on this edge (takes priority over run)
//   load_val  value to load
//   run       decrement by one on this edge while the count is non-zero
//   expired   registered flag, high whenever the count is zero
//
// Loading N-1 makes expired visible to the user logic on the Nth edge after
// the load, which is how the deframer turns a cycle limit into an event.
// -----------------------------------------------------------------------------
module score_rx_timer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             run,
   output logic             expired
);

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] cnt_r;
   logic [WIDTH-1:0] cnt_next_s;
   logic             expired_r;

   // Next count: load wins, otherwise count down towards zero and stop there.
   always_comb begin
      cnt_next_s = cnt_r;
      if (load) begin
         cnt_next_s = load_val;
      end else if (run && (cnt_r != ZERO)) begin
         cnt_next_s = cnt_r - ONE;
      end else begin
         cnt_next_s = cnt_r;
      end
   end

   // Count register; the flag is registered from the next count so it always
   // matches the count held in cnt_r.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         cnt_r     <= ZERO;
         expired_r <= 1'b1;
      end else begin
         cnt_r     <= cnt_next_s;
         expired_r <= (cnt_next_s == ZERO);
      end
   end

   assign expired = expired_r;

endmodule

// File: rtl/score_rx_deframer.sv
// -----------------------------------------------------------------------------
// score_rx_deframer
// Receive-side deframer for the two-player score link. Takes bytes from the
// UART receiver, hunts for SYNC_BYTE, reassembles the opponent's 24-bit packed
// BCD score (MSB byte first), validates it and presents it to the renderer
// with a one-cycle update strobe.
//
// Parameters:
//   BYTE_TIMEOUT  max edges between accepted bytes inside a frame
//   LINK_TIMEOUT  edges without a good frame before link_up drops
//
// Ports:
//   pclk         clock, rising edge
//   rst          asynchronous active-low reset
//   rx_byte      received byte (UART dout)
//   rx_rdy       UART byte-ready level, stays high until cleared
//   rx_rdy_clr   one-cycle clear pulse to the UART, cycle after acceptance
//   opp_score    last good score, packed BCD, held between frames
//   score_valid  one-cycle pulse when opp_score is (re)written
//   frame_err    one-cycle pulse on any frame rejection
//   err_cnt      saturating count of rejected frames
//   link_up      high while good frames arrive within LINK_TIMEOUT
//
// Build option: define SCORE_RX_CHECKSUM_EN to expect a fourth payload byte
// equal to B2^B1^B0; the commit then moves from B0 to CHK.
// -----------------------------------------------------------------------------
module score_rx_deframer
   import score_link_pkg::*;
#(
   parameter int unsigned BYTE_TIMEOUT = 32'd750000,
   parameter int unsigned LINK_TIMEOUT = 32'd75000000
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [7:0]  rx_byte,
   input  logic        rx_rdy,
   output logic        rx_rdy_clr,
   output logic [23:0] opp_score,
   output logic        score_valid,
   output logic        frame_err,
   output logic [7:0]  err_cnt,
   output logic        link_up
);

   // Timers report expiry on the Nth edge after a load of N-1.
   localparam logic [31:0] BYTE_LOAD   = 32'(BYTE_TIMEOUT - 32'd1);
   localparam logic [31:0] LINK_LOAD   = 32'(LINK_TIMEOUT - 32'd1);
   // Edges after an acceptance during which rx_rdy is ignored; covers the
   // UART's reaction time to rx_rdy_clr.
   localparam logic [1:0]  GUARD_EDGES = 2'd2;

   rx_state_e   state_r;
   logic [23:0] shadow_r;
   logic [1:0]  guard_r;
   logic        rx_rdy_clr_r;
   logic [23:0] opp_score_r;
   logic        score_valid_r;
   logic        frame_err_r;
   logic [7:0]  err_cnt_r;
   logic        link_up_r;

   logic        accept_s;
   logic        bcd_ok_s;
   logic        is_sync_s;
   logic        byte_run_s;
   logic        byte_expired_s;
   logic        link_expired_s;
   logic        commit_s;
   logic        reject_s;
   logic [23:0] commit_score_s;
   rx_state_e   bad_byte_next_s;

   assign accept_s   = rx_rdy && (guard_r == 2'd0);
   assign bcd_ok_s   = bcd_byte_ok(rx_byte);
   assign is_sync_s  = (rx_byte == SYNC_BYTE);
   assign byte_run_s = (state_r != HUNT);

   // A non-BCD byte inside a frame aborts it; if it is the sync byte itself
   // it also starts the next frame.
   always_comb begin
      if (is_sync_s) begin
         bad_byte_next_s = B2;
      end else begin
         bad_byte_next_s = HUNT;
      end
   end

   // Per-edge frame decision: commit, reject, or nothing. An accepted byte
   // takes precedence over a byte timeout on the same edge.
   always_comb begin
      commit_s       = 1'b0;
      reject_s       = 1'b0;
      commit_score_s = shadow_r;
      if (accept_s) begin
         case (state_r)
            HUNT: begin
               commit_s = 1'b0;
               reject_s = 1'b0;
            end
            B2, B1: begin
               reject_s = !bcd_ok_s;
            end
            B0: begin
               reject_s = !bcd_ok_s;
`ifdef SCORE_RX_CHECKSUM_EN
               commit_s = 1'b0;
`else
               commit_s       = bcd_ok_s;
               commit_score_s = {shadow_r[23:8], rx_byte};
`endif
            end
            CHK: begin
               // Checksum byte is compared only; it is never taken as sync.
               commit_s = (rx_byte == frame_checksum(shadow_r));
               reject_s = (rx_byte != frame_checksum(shadow_r));
            end
            default: begin
               commit_s = 1'b0;
               reject_s = 1'b0;
            end
         endcase
      end else if (byte_run_s && byte_expired_s) begin
         reject_s = 1'b1;
      end else begin
         reject_s = 1'b0;
      end
   end

   // Inter-byte timeout: reloaded by every accepted byte, counts outside HUNT.
   score_rx_timer #(.WIDTH(32)) u_byte_timer (
      .pclk     (pclk),
      .rst      (rst),
      .load     (accept_s),
      .load_val (BYTE_LOAD),
      .run      (byte_run_s),
      .expired  (byte_expired_s)
   );

   // Link-alive timeout: reloaded by every committed frame, always counting.
   score_rx_timer #(.WIDTH(32)) u_link_timer (
      .pclk     (pclk),
      .rst      (rst),
      .load     (commit_s),
      .load_val (LINK_LOAD),
      .run      (1'b1),
      .expired  (link_expired_s)
   );

   // Frame state machine with registered outputs, guard and error counter.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         state_r       <= HUNT;
         shadow_r      <= 24'h000000;
         guard_r       <= 2'd0;
         rx_rdy_clr_r  <= 1'b0;
         opp_score_r   <= 24'h000000;
         score_valid_r <= 1'b0;
         frame_err_r   <= 1'b0;
         err_cnt_r     <= 8'h00;
         link_up_r     <= 1'b0;
      end else begin
         rx_rdy_clr_r  <= accept_s;
         score_valid_r <= commit_s;
         frame_err_r   <= reject_s;

         if (accept_s) begin
            guard_r <= GUARD_EDGES;
         end else if (guard_r != 2'd0) begin
            guard_r <= guard_r - 2'd1;
         end else begin
            guard_r <= 2'd0;
         end

         if (reject_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
         end

         // A commit on the same edge as link expiry keeps the link up.
         if (commit_s) begin
            opp_score_r <= commit_score_s;
            link_up_r   <= 1'b1;
         end else if (link_expired_s) begin
            link_up_r   <= 1'b0;
         end

         if (accept_s) begin
            case (state_r)
               HUNT: begin
                  if (is_sync_s) begin
                     state_r  <= B2;
                     shadow_r <= 24'h000000;
                  end
               end
               B2: begin
                  if (bcd_ok_s) begin
                     shadow_r[23:16] <= rx_byte;
                     state_r         <= B1;
                  end else begin
                     state_r  <= bad_byte_next_s;
                     shadow_r <= 24'h000000;
                  end
               end
               B1: begin
                  if (bcd_ok_s) begin
                     shadow_r[15:8] <= rx_byte;
                     state_r        <= B0;
                  end else begin
                     state_r  <= bad_byte_next_s;
                     shadow_r <= 24'h000000;
                  end
               end
               B0: begin
                  if (bcd_ok_s) begin
                     shadow_r[7:0] <= rx_byte;
`ifdef SCORE_RX_CHECKSUM_EN
                     state_r       <= CHK;
`else
                     state_r       <= HUNT;
`endif
                  end else begin
                     state_r  <= bad_byte_next_s;
                     shadow_r <= 24'h000000;
                  end
               end
               CHK: begin
                  state_r  <= HUNT;
                  shadow_r <= 24'h000000;
               end
               default: begin
                  state_r  <= HUNT;
                  shadow_r <= 24'h000000;
               end
            endcase
         end else if (reject_s) begin
            // Byte timeout: drop the partial frame.
            state_r  <= HUNT;
            shadow_r <= 24'h000000;
         end
      end
   end

   assign rx_rdy_clr  = rx_rdy_clr_r;
   assign opp_score   = opp_score_r;
   assign score_valid = score_valid_r;
   assign frame_err   = frame_err_r;
   assign err_cnt     = err_cnt_r;
   assign link_up     = link_up_r;

endmodule

// File: tb/tb_score_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_score_rx_deframer
// Self-checking bench for score_rx_deframer with shortened timeouts. A
// rule-level reference model (edge counters and a payload queue) predicts
// every output on every edge; a table of frames with fixed expected results,
// a few hand-built corner sequences and a randomized frame mix drive it.
// Follows SCORE_RX_CHECKSUM_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_score_rx_deframer;

   localparam int BT = 20;
   localparam int LT = 300;
`ifdef SCORE_RX_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic        pclk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        rx_rdy = 1'b0;
   logic        rx_rdy_clr;
   logic [23:0] opp_score;
   logic        score_valid;
   logic        frame_err;
   logic [7:0]  err_cnt;
   logic        link_up;

   always #5 pclk = ~pclk;

   score_rx_deframer #(.BYTE_TIMEOUT(BT), .LINK_TIMEOUT(LT)) dut (
      .pclk        (pclk),
      .rst         (rst),
      .rx_byte     (rx_byte),
      .rx_rdy      (rx_rdy),
      .rx_rdy_clr  (rx_rdy_clr),
      .opp_score   (opp_score),
      .score_valid (score_valid),
      .frame_err   (frame_err),
      .err_cnt     (err_cnt),
      .link_up     (link_up)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: edge number k, edges of last acceptance / last commit.
   int         k = 0;
   int         last_acc = -1000;
   int         last_commit = -1000;
   bit         synced = 1'b0;
   logic [7:0] pay[$];
   logic [23:0] m_score = 24'h0;
   bit         m_valid, m_err, m_clr, m_link;
   int         m_errcnt = 0;

   int n_valid, n_err, n_clr;

   typedef struct packed {
      logic [63:0] bytes;
      int          n;
      logic [23:0] sc;
      int          nv;
      int          ne;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s edge=%0d actual=%h required=%h", name, k, act, exp);
      end
   endtask

   task automatic model_reset();
      synced = 1'b0;
      pay.delete();
      last_acc = k - 1000;
      last_commit = k - 1000;
      m_score = 24'h0;
      m_valid = 1'b0;
      m_err = 1'b0;
      m_clr = 1'b0;
      m_link = 1'b0;
      m_errcnt = 0;
   endtask

   task automatic model_step();
      bit acc;
      k++;
      acc = rx_rdy && (k - last_acc >= 3);
      m_valid = 1'b0;
      m_err = 1'b0;
      m_clr = acc;
      if (acc) begin
         last_acc = k;
         if (!synced) begin
            if (rx_byte == 8'hA5) begin
               synced = 1'b1;
               pay.delete();
            end
         end else if (CHK_EN && pay.size() == 3) begin
            if (rx_byte == (pay[0] ^ pay[1] ^ pay[2])) begin
               m_score = {pay[0], pay[1], pay[2]};
               m_valid = 1'b1;
               last_commit = k;
            end else begin
               m_err = 1'b1;
            end
            synced = 1'b0;
         end else if (rx_byte[7:4] <= 4'd9 && rx_byte[3:0] <= 4'd9) begin
            pay.push_back(rx_byte);
            if (!CHK_EN && pay.size() == 3) begin
               m_score = {pay[0], pay[1], pay[2]};
               m_valid = 1'b1;
               last_commit = k;
               synced = 1'b0;
            end
         end else begin
            m_err = 1'b1;
            synced = (rx_byte == 8'hA5);
            pay.delete();
         end
      end else if (synced && (k - last_acc >= BT)) begin
         m_err = 1'b1;
         synced = 1'b0;
      end
      if (m_err && m_errcnt < 255) m_errcnt++;
      if (m_valid) m_link = 1'b1;
      else if (m_link && (k - last_commit >= LT)) m_link = 1'b0;
   endtask

   task automatic compare_all();
      chk("rx_rdy_clr", 32'(rx_rdy_clr), 32'(m_clr));
      chk("score_valid", 32'(score_valid), 32'(m_valid));
      chk("frame_err", 32'(frame_err), 32'(m_err));
      chk("opp_score", 32'(opp_score), 32'(m_score));
      chk("err_cnt", 32'(err_cnt), 32'(m_errcnt));
      chk("link_up", 32'(link_up), 32'(m_link));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_clr"}, 32'(rx_rdy_clr), 32'd0);
      chk({tag, "_valid"}, 32'(score_valid), 32'd0);
      chk({tag, "_err"}, 32'(frame_err), 32'd0);
      chk({tag, "_score"}, 32'(opp_score), 32'd0);
      chk({tag, "_errcnt"}, 32'(err_cnt), 32'd0);
      chk({tag, "_link"}, 32'(link_up), 32'd0);
   endtask

   task automatic tick();
      @(posedge pclk);
      model_step();
      #1;
      compare_all();
      n_valid += int'(score_valid);
      n_err   += int'(frame_err);
      n_clr   += int'(rx_rdy_clr);
   endtask

   task automatic send_hold(input logic [7:0] b, input int hold, input int gap);
      rx_byte = b;
      rx_rdy = 1'b1;
      repeat (hold) tick();
      rx_rdy = 1'b0;
      rx_byte = 8'($urandom);
      repeat (gap - 1) tick();
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      send_hold(b, 1, gap);
   endtask

   task automatic send_good(input logic [23:0] s, input int gap);
      send(8'hA5, gap);
      send(s[23:16], gap);
      send(s[15:8], gap);
      send(s[7:0], gap);
      if (CHK_EN) send(s[23:16] ^ s[15:8] ^ s[7:0], gap);
   endtask

   function automatic logic [7:0] rand_bcd();
      return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
   endfunction

   function automatic int rand_gap();
      if ($urandom_range(0, 9) < 8) return $urandom_range(3, 6);
      else return BT - 1 + $urandom_range(0, 2);
   endfunction

   task automatic clear_counts();
      n_valid = 0;
      n_err = 0;
      n_clr = 0;
   endtask

   initial begin
`ifdef SCORE_RX_CHECKSUM_EN
      tbl[0] = '{64'hA5987654BA000000, 5, 24'h987654, 1, 0};
      tbl[1] = '{64'hA598765400000000, 5, 24'h987654, 0, 1};
      tbl[2] = '{64'hA512A50001999800, 7, 24'h000199, 1, 1};
      tbl[3] = '{64'hA5123456A5000000, 5, 24'h000199, 0, 1};
      tbl[4] = '{64'h1234567000000000, 4, 24'h000199, 0, 0};
      tbl[5] = '{64'h3CA51F0000000000, 3, 24'h000199, 0, 1};
      tbl[6] = '{64'hA599999999000000, 5, 24'h999999, 1, 0};
      tbl[7] = '{64'hA500000000000000, 5, 24'h000000, 1, 0};
`else
      tbl[0] = '{64'hA512345600000000, 4, 24'h123456, 1, 0};
      tbl[1] = '{64'hA512A50001990000, 6, 24'h000199, 1, 1};
      tbl[2] = '{64'h3CA51F0000000000, 3, 24'h000199, 0, 1};
      tbl[3] = '{64'hA599999900000000, 4, 24'h999999, 1, 0};
      tbl[4] = '{64'hA500000000000000, 4, 24'h000000, 1, 0};
      tbl[5] = '{64'hA5129A0000000000, 3, 24'h000000, 0, 1};
      tbl[6] = '{64'hA5A9000000000000, 2, 24'h000000, 0, 1};
      tbl[7] = '{64'hA500000000000000, 4, 24'h000000, 1, 0};
`endif
      clear_counts();

      // Power-on reset values.
      #2;
      check_zero("reset");
      @(negedge pclk);
      @(negedge pclk);
      rst = 1'b1;
      model_reset();
      repeat (3) tick();

      // Table of frames with fixed expectations.
      for (int i = 0; i < 8; i++) begin
         clear_counts();
         for (int j = 0; j < tbl[i].n; j++) begin
            send(tbl[i].bytes[63 - 8 * j -: 8], $urandom_range(3, 5));
         end
         repeat (2) tick();
         chk($sformatf("tbl%0d_score", i), 32'(opp_score), 32'(tbl[i].sc));
         chk($sformatf("tbl%0d_valid", i), 32'(n_valid), 32'(tbl[i].nv));
         chk($sformatf("tbl%0d_err", i), 32'(n_err), 32'(tbl[i].ne));
         chk($sformatf("tbl%0d_clr", i), 32'(n_clr), 32'(tbl[i].n));
      end
      chk("tbl_link", 32'(link_up), 32'd1);

      // rx_rdy held through the guard window: one byte only.
      clear_counts();
      send_hold(8'h33, 3, 4);
      chk("hold_one_accept", 32'(n_clr), 32'd1);

      // Byte timeout after A5,12.
      send(8'hA5, 3);
      send(8'h12, 1);
      clear_counts();
      repeat (BT - 1) tick();
      chk("bto_not_early", 32'(n_err), 32'd0);
      tick();
      chk("bto_fires", 32'(frame_err), 32'd1);

      // Bytes exactly at the timeout limit: acceptance wins.
      clear_counts();
      send_good(24'h123456, BT);
      chk("bto_accept_wins_score", 32'(opp_score), 32'h123456);
      chk("bto_accept_wins_err", 32'(n_err), 32'd0);

      // Link timeout with score retained.
      send_good(24'h000321, 3);
      repeat (LT - 3) tick();
      chk("link_before_expiry", 32'(link_up), 32'd1);
      tick();
      chk("link_expired", 32'(link_up), 32'd0);
      chk("link_score_held", 32'(opp_score), 32'h000321);

      // Commit on the same edge the link would expire.
      send_good(24'h000042, 3);
      repeat (LT - 3 * (CHK_EN ? 4 : 3) - 3) tick();
      send_good(24'h000777, 3);
      chk("link_commit_wins", 32'(link_up), 32'd1);
      chk("link_commit_score", 32'(opp_score), 32'h000777);

      // Randomized frame mix against the model.
      for (int it = 0; it < 250; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: send_good({rand_bcd(), rand_bcd(), rand_bcd()}, rand_gap());
            4: send(8'($urandom), rand_gap());
            5: send(8'hA5, rand_gap());
            6: send(rand_bcd(), rand_gap());
            7: repeat (BT + $urandom_range(0, 3)) tick();
            8: send_hold(8'($urandom), $urandom_range(1, 5), rand_gap());
            default: begin
               send(8'hA5, 3);
               send(rand_bcd(), 3);
               send(rand_bcd(), 3);
               send(rand_bcd(), 3);
               if (CHK_EN) send(8'($urandom), 3);
            end
         endcase
      end

      // Reset in the middle of a frame.
      send(8'hA5, 3);
      send(8'h12, 2);
      #2;
      rst = 1'b0;
      #1;
      check_zero("midreset");
      @(negedge pclk);
      @(negedge pclk);
      rst = 1'b1;
      model_reset();
      send_good(24'h456789, 3);
      chk("after_reset_score", 32'(opp_score), 32'h456789);

      // Error counter saturation.
      for (int i = 0; i < 300; i++) begin
         send(8'hA5, 3);
         send(8'h1F, 3);
      end
      chk("err_saturated", 32'(err_cnt), 32'd255);
      send(8'hA5, 3);
      send(8'hFF, 3);
      chk("err_stays_saturated", 32'(err_cnt), 32'd255);
      chk("sat_score_held", 32'(opp_score), 32'h456789);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
